// File: rtl/ysyx_23060077_riscv_axi_burst_sram.sv
// AXI4 INCR-burst SRAM model with independent read and write channels.
// Response latency is fixed (MAX_DELAY) or drawn from a shared 8-bit LFSR.
//
// Write FSM
//   state   | meaning
//   W_IDLE  | waiting for an aw handshake
//   W_DATA  | accepting write beats until w_last
//   W_DELAY | counting down the response delay
//   W_RESP  | b_valid held until b_ready
// Read FSM
//   state   | meaning
//   R_IDLE  | waiting for an ar handshake
//   R_DELAY | counting down the first-beat delay
//   R_DATA  | streaming beats, one per handshake
module ysyx_23060077_riscv_axi_burst_sram #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int MAX_DELAY  = 7,
    parameter int RAND_DELAY = 1
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic                axi_sram_aw_valid_i,
    output logic                axi_sram_aw_ready_o,
    input  logic [ADDR_W-1:0]   axi_sram_aw_addr_i,
    input  logic [7:0]          axi_sram_aw_len_i,
    input  logic                axi_sram_w_valid_i,
    output logic                axi_sram_w_ready_o,
    input  logic [DATA_W-1:0]   axi_sram_w_data_i,
    input  logic [DATA_W/8-1:0] axi_sram_w_strb_i,
    input  logic                axi_sram_w_last_i,
    output logic                axi_sram_b_valid_o,
    input  logic                axi_sram_b_ready_i,
    output logic [1:0]          axi_sram_b_resp_o,
    input  logic                axi_sram_ar_valid_i,
    output logic                axi_sram_ar_ready_o,
    input  logic [ADDR_W-1:0]   axi_sram_ar_addr_i,
    input  logic [7:0]          axi_sram_ar_len_i,
    output logic                axi_sram_r_valid_o,
    input  logic                axi_sram_r_ready_i,
    output logic [DATA_W-1:0]   axi_sram_r_data_o,
    output logic [1:0]          axi_sram_r_resp_o,
    output logic                axi_sram_r_last_o
);
    localparam int         STRB_W  = DATA_W / 8;
    localparam int         OFF     = $clog2(STRB_W);
    localparam int         DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [8:0] DLY_MOD = 9'(MAX_DELAY + 1);
    localparam logic [7:0] DLY_FIX = 8'(MAX_DELAY);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_DELAY, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_DELAY, R_DATA} r_state_t;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [7:0]            lfsr;
    logic [7:0]            delay_val;
    w_state_t              w_state, w_next;
    r_state_t              r_state, r_next;
    logic [DEPTH_LOG2-1:0] w_idx, r_idx, load_idx;
    logic [7:0]            w_len, w_cnt, r_len, r_cnt, r_beat, load_beat, load_len;
    logic [8:0]            w_beats;
    logic                  w_err, r_err, load_err;
    logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs, r_load;
    logic                  aw_oob, ar_oob;
    logic                  unused_bits;

    // Unaligned low address bits do not select anything.
    assign unused_bits = ^{axi_sram_aw_addr_i[OFF-1:0], axi_sram_ar_addr_i[OFF-1:0]};

    assign axi_sram_aw_ready_o = ~areset & (w_state == W_IDLE);
    assign axi_sram_w_ready_o  = ~areset & (w_state == W_DATA);
    assign axi_sram_b_valid_o  = ~areset & (w_state == W_RESP);
    assign axi_sram_ar_ready_o = ~areset & (r_state == R_IDLE);
    assign axi_sram_r_valid_o  = ~areset & (r_state == R_DATA);

    assign aw_hs = axi_sram_aw_valid_i & axi_sram_aw_ready_o;
    assign w_hs  = axi_sram_w_valid_i  & axi_sram_w_ready_o;
    assign b_hs  = axi_sram_b_valid_o  & axi_sram_b_ready_i;
    assign ar_hs = axi_sram_ar_valid_i & axi_sram_ar_ready_o;
    assign r_hs  = axi_sram_r_valid_o  & axi_sram_r_ready_i;

    assign aw_oob = (axi_sram_aw_addr_i >> (OFF + DEPTH_LOG2)) != '0;
    assign ar_oob = (axi_sram_ar_addr_i >> (OFF + DEPTH_LOG2)) != '0;

    if (RAND_DELAY != 0) begin : g_rand
        assign delay_val = 8'({1'b0, lfsr} % DLY_MOD);
    end else begin : g_fixed
        assign delay_val = DLY_FIX;
    end

    // Free-running LFSR shared by both channels, x^8+x^6+x^5+x^4+1.
    always_ff @(posedge aclk) begin
        if (areset) lfsr <= 8'h01;
        else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    // State registers for both channel FSMs.
    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    // Write next-state; a zero delay skips W_DELAY so b_valid lands at T+1.
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && axi_sram_w_last_i)
                         w_next = (delay_val == 8'd0) ? W_RESP : W_DELAY;
            W_DELAY: if (w_cnt == 8'd0) w_next = W_RESP;
            W_RESP:  if (b_hs) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // Read next-state; a zero delay loads the first beat straight from idle.
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = (delay_val == 8'd0) ? R_DATA : R_DELAY;
            R_DELAY: if (r_cnt == 8'd0) r_next = R_DATA;
            R_DATA:  if (r_hs && axi_sram_r_last_o) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Write bookkeeping: burst pointer, beat count, delay timer, response code.
    always_ff @(posedge aclk) begin
        if (areset) begin
            w_idx             <= '0;
            w_len             <= '0;
            w_beats           <= '0;
            w_err             <= 1'b0;
            w_cnt             <= '0;
            axi_sram_b_resp_o <= 2'b00;
        end else begin
            if (aw_hs) begin
                w_idx             <= axi_sram_aw_addr_i[OFF +: DEPTH_LOG2];
                w_len             <= axi_sram_aw_len_i;
                w_beats           <= '0;
                w_err             <= aw_oob;
                axi_sram_b_resp_o <= 2'b00;
            end
            if (w_hs) begin
                w_idx   <= w_idx + 1'b1;
                w_beats <= w_beats + 1'b1;
                if (axi_sram_w_last_i) begin
                    w_cnt             <= delay_val - 8'd1;
                    axi_sram_b_resp_o <= (w_err || (w_beats != {1'b0, w_len})) ? 2'b10 : 2'b00;
                end
            end
            if (w_state == W_DELAY && w_cnt != 8'd0) w_cnt <= w_cnt - 8'd1;
        end
    end

    // Byte-masked array write at each accepted in-range beat; not reset.
    always_ff @(posedge aclk) begin
        if (w_hs && !w_err) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (axi_sram_w_strb_i[b]) mem[w_idx][8*b +: 8] <= axi_sram_w_data_i[8*b +: 8];
            end
        end
    end

    // Source of the beat being loaded: the ar inputs when leaving idle directly.
    always_comb begin
        if (r_state == R_IDLE) begin
            load_idx  = axi_sram_ar_addr_i[OFF +: DEPTH_LOG2];
            load_beat = 8'd0;
            load_len  = axi_sram_ar_len_i;
            load_err  = ar_oob;
        end else begin
            load_idx  = r_idx;
            load_beat = r_beat;
            load_len  = r_len;
            load_err  = r_err;
        end
    end

    assign r_load = (r_next == R_DATA) && ((r_state != R_DATA) || r_hs);

    // Read bookkeeping and beat registers; beat outputs only change on a load.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_idx             <= '0;
            r_len             <= '0;
            r_beat            <= '0;
            r_err             <= 1'b0;
            r_cnt             <= '0;
            axi_sram_r_data_o <= '0;
            axi_sram_r_resp_o <= 2'b00;
            axi_sram_r_last_o <= 1'b0;
        end else begin
            if (ar_hs) begin
                r_idx  <= axi_sram_ar_addr_i[OFF +: DEPTH_LOG2];
                r_len  <= axi_sram_ar_len_i;
                r_beat <= 8'd0;
                r_err  <= ar_oob;
                r_cnt  <= delay_val - 8'd1;
            end
            if (r_state == R_DELAY && r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
            if (r_load) begin
                axi_sram_r_data_o <= load_err ? '0 : mem[load_idx];
                axi_sram_r_resp_o <= load_err ? 2'b10 : 2'b00;
                axi_sram_r_last_o <= (load_beat == load_len);
                r_idx             <= load_idx + 1'b1;
                r_beat            <= load_beat + 8'd1;
            end
        end
    end
endmodule

// File: doc/ysyx_23060077_riscv_axi_burst_sram.md
YSYX_23060077_RISCV_AXI_BURST_SRAM -- requirements
Module: ysyx_23060077_riscv_axi_burst_sram

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data width in bits, power of two, 32 or 64.
REQ-002 SHALL have parameter ADDR_W, default 32: byte address width.
REQ-003 SHALL have parameter DEPTH_LOG2, default 10: log2 of the word count of the internal array.
REQ-004 SHALL have parameter MAX_DELAY, default 7: maximum response delay in cycles, range 0..255.
REQ-005 SHALL have parameter RAND_DELAY, default 1: 1 = LFSR-random delay, 0 = fixed MAX_DELAY.
REQ-006 SHALL have port aclk  in  1  clock, all logic rising-edge.
REQ-007 SHALL have port areset  in  1  synchronous, active-high reset.
REQ-008 SHALL have ports axi_sram_aw_valid_i in 1 and axi_sram_aw_ready_o out 1: write-address handshake.
REQ-009 SHALL have port axi_sram_aw_addr_i  in  ADDR_W  burst start byte address.
REQ-010 SHALL have port axi_sram_aw_len_i  in  8  write beats minus 1.
REQ-011 SHALL have ports axi_sram_w_valid_i in 1 and axi_sram_w_ready_o out 1: write-data handshake.
REQ-012 SHALL have ports axi_sram_w_data_i in DATA_W, axi_sram_w_strb_i in DATA_W/8, axi_sram_w_last_i in 1.
REQ-013 SHALL have ports axi_sram_b_valid_o out 1, axi_sram_b_ready_i in 1, axi_sram_b_resp_o out 2: write response.
REQ-014 SHALL have ports axi_sram_ar_valid_i in 1, axi_sram_ar_ready_o out 1, axi_sram_ar_addr_i in ADDR_W, axi_sram_ar_len_i in 8.
REQ-015 SHALL have ports axi_sram_r_valid_o out 1, axi_sram_r_ready_i in 1, axi_sram_r_data_o out DATA_W, axi_sram_r_resp_o out 2, axi_sram_r_last_o out 1.

Function
REQ-016 SHALL hold a 2^DEPTH_LOG2 x DATA_W array; word index = addr >> log2(DATA_W/8), low DEPTH_LOG2 bits; unaligned low bits ignored.
REQ-017 SHALL treat a burst as out of range when the start address is >= 2^DEPTH_LOG2*DATA_W/8: writes suppressed, reads return 0, resp = 2'b10 (SLVERR); otherwise resp = 2'b00.
REQ-018 SHALL run INCR bursts only: beat k uses index (start+k) mod 2^DEPTH_LOG2, so the index wraps at the array top.
REQ-019 SHALL run write FSM W_IDLE -> W_DATA on the aw handshake; in W_DATA, accept beats and go to W_DELAY on the beat with w_last=1; in W_DELAY, count down to W_RESP; in W_RESP, hold b_valid=1 until b_ready, then return to W_IDLE.
REQ-020 SHALL drive aw_ready=1 only in W_IDLE and w_ready=1 only in W_DATA; ar_ready=1 only in R_IDLE.
REQ-021 SHALL commit each accepted write beat at its handshake edge, byte-masked by strb; strb=0 changes nothing.
REQ-022 SHALL report b_resp=2'b10 when the beat count at w_last differs from len+1; beats already committed remain.
REQ-023 SHALL run read FSM R_IDLE -> R_DELAY on the ar handshake -> R_DATA -> R_IDLE after the last-beat handshake; r_last=1 only on beat len.
REQ-024 SHALL hold r_data, r_resp and r_last stable while r_valid=1 and r_ready=0; the next beat follows in the cycle after a handshake, with no inter-beat delay.
REQ-025 SHALL assert first r_valid at T+1+D, where T is the ar handshake cycle, and b_valid at T+1+D, where T is the last w handshake cycle; D = MAX_DELAY if RAND_DELAY=0, else lfsr mod (MAX_DELAY+1) sampled at T.
REQ-026 SHALL use an 8-bit Fibonacci LFSR x^8+x^6+x^5+x^4+1, seed 8'h01, advancing every cycle; it is shared, with independent read and write counters.
REQ-027 SHALL sample read data for each beat from the array in the cycle the beat is loaded; a write committed in that same cycle becomes visible one cycle later.
REQ-028 SHALL keep read and write channels fully concurrent, with no ordering between them.

Reset
REQ-029 SHALL, while areset=1, force all FSMs to IDLE, all outputs to 0 (ready/valid/resp/last/data), LFSR to 8'h01 and counters to 0; aw_ready and ar_ready rise in the first cycle after release.
REQ-030 SHALL abort any burst in flight on reset with no b/r response; array contents are unaffected by reset (zero at time 0).

Verification (DATA_W=32, DEPTH_LOG2=8, RAND_DELAY=0, MAX_DELAY=2)
REQ-031 Write 0x10 len 0, data 0xDEADBEEF, strb 0xF, w handshake at T -> b_valid at T+3, resp 00; read 0x10 -> r_valid at T'+3, data 0xDEADBEEF, r_last=1.
REQ-032 Write 0x10 data 0x00001234 strb 0x3 -> readback 0xDEAD1234.
REQ-033 Write 0x3F8 len 3, data 1,2,3,4 -> words 254,255,0,1 written; read 0x3F8 len 3 -> 1,2,3,4, r_last only on 4th beat.
REQ-034 Write/read 0x400 -> b_resp 10, array unchanged, r_data 0, r_resp 10; write len 3 with w_last on beat 2 -> b_resp 10.
REQ-035 Read len 3 with r_ready low 5 cycles at beat 2 -> r_data and r_last stable; back-to-back handshakes, 4 beats in 4 cycles.
REQ-036 areset pulse after 2 of 4 write beats -> no b_valid, w_ready=0, aw_ready=1 first cycle after release, 2 beats retained.
